// File: rtl/freq_meter_core_if.sv
// -----------------------------------------------------------------------------
// freq_meter_core_if
// Signal bundle between the frequency meter core and its surroundings.
//   sigin     signal under test (asynchronous to sysclk)
//   freq      edges counted in the last completed gate window
//   freq_vld  one-cycle pulse when freq/overflow update
//   overflow  last gate window saturated the edge counter
//   freq_bcd  8 BCD digits of freq (zero when the converter is not built)
//   bcd_vld   one-cycle pulse when freq_bcd updates
// Modports: master = meter core, slave = signal source / readout side.
// -----------------------------------------------------------------------------
interface freq_meter_core_if #(
    parameter int unsigned COUNT_W = 24
);
    logic               sigin;
    logic [COUNT_W-1:0] freq;
    logic               freq_vld;
    logic               overflow;
    logic [31:0]        freq_bcd;
    logic               bcd_vld;

    modport master (
        input  sigin,
        output freq, freq_vld, overflow, freq_bcd, bcd_vld
    );

    modport slave (
        output sigin,
        input  freq, freq_vld, overflow, freq_bcd, bcd_vld
    );
endinterface

// File: rtl/freq_meter_core.sv
// -----------------------------------------------------------------------------
// freq_meter_core
// Counts rising edges of an asynchronous square wave over back-to-back gate
// windows of GATE_CYCLES sysclk cycles and publishes the count as a frequency.
// Optional binary-to-BCD converter built when the macro FREQ_BCD_EN is defined;
// without it freq_bcd and bcd_vld are tied low.
// Ports:
//   sysclk  system clock
//   reset   synchronous, active-high reset
//   bus     freq_meter_core_if.master (sigin in; freq, freq_vld, overflow,
//           freq_bcd, bcd_vld out)
// Parameters:
//   GATE_CYCLES  sysclk cycles per gate window (>= COUNT_W+4)
//   COUNT_W      width of the edge counter and result (<= 26 with BCD)
//
// BCD converter states:
//   state    | meaning
//   ST_IDLE  | waiting for freq_vld
//   ST_SHIFT | double-dabble, one bit per cycle, COUNT_W cycles
//   ST_DONE  | publish scratch to freq_bcd, pulse bcd_vld
// -----------------------------------------------------------------------------
module freq_meter_core #(
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned COUNT_W     = 24
) (
    input  logic              sysclk,
    input  logic              reset,
    freq_meter_core_if.master bus
);

    localparam int unsigned      GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic               sync1, sync2, sync3;
    logic               rise;
    logic [GW-1:0]      gate_cnt;
    logic               tick;
    logic [COUNT_W-1:0] edge_cnt;
    logic               sat;
    logic               cnt_full;
    logic [COUNT_W-1:0] freq_r;
    logic               freq_vld_r;
    logic               overflow_r;

    // Two flops to resolve metastability, third flop for edge detection.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= bus.sigin;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            gate_cnt <= '0;
        end else if (tick) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    assign tick     = (gate_cnt == GATE_LAST);
    assign cnt_full = (edge_cnt == CNT_MAX);

    // A rise on the tick cycle is folded into the ending window, so windows
    // abut with no lost or double-counted edges.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq_r     <= '0;
            freq_vld_r <= 1'b0;
            overflow_r <= 1'b0;
        end else if (tick) begin
            freq_r     <= cnt_full ? CNT_MAX : edge_cnt + COUNT_W'(rise);
            overflow_r <= sat | (cnt_full & rise);
            freq_vld_r <= 1'b1;
            edge_cnt   <= '0;
            sat        <= 1'b0;
        end else begin
            freq_vld_r <= 1'b0;
            if (rise) begin
                if (cnt_full) begin
                    sat <= 1'b1;
                end else begin
                    edge_cnt <= edge_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.freq     = freq_r;
    assign bus.freq_vld = freq_vld_r;
    assign bus.overflow = overflow_r;

`ifdef FREQ_BCD_EN
    localparam int unsigned    IW         = (COUNT_W > 1) ? $clog2(COUNT_W) : 1;
    localparam logic [IW-1:0]  SHIFT_LAST = IW'(COUNT_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state;
    logic [COUNT_W-1:0] shreg;
    logic [31:0]        scratch;
    logic [31:0]        scratch_adj;
    logic [31:0]        bcd_r;
    logic [IW-1:0]      bit_idx;
    logic               bcd_vld_r;

    // Pre-shift correction: any digit >= 5 would exceed 9 after doubling.
    always_comb begin
        scratch_adj = scratch;
        for (int k = 0; k < 8; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            scratch   <= '0;
            bcd_r     <= '0;
            bit_idx   <= '0;
            bcd_vld_r <= 1'b0;
        end else begin
            bcd_vld_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (freq_vld_r) begin
                        shreg   <= freq_r;
                        scratch <= '0;
                        bit_idx <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    scratch <= {scratch_adj[30:0], shreg[COUNT_W-1]};
                    shreg   <= shreg << 1;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == SHIFT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bcd_r     <= scratch;
                    bcd_vld_r <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.freq_bcd = bcd_r;
    assign bus.bcd_vld  = bcd_vld_r;
`else
    assign bus.freq_bcd = 32'd0;
    assign bus.bcd_vld  = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter_core.sv
// -----------------------------------------------------------------------------
// tb_freq_meter_core
// Two meter instances share one stimulus: a 24-bit counter and a 6-bit counter
// that saturates. A window-level model predicts every output on every cycle:
// an input transition sampled at edge k is a rising edge counted at edge k+2,
// windows close every GATE sysclk edges after reset, and the BCD result
// follows COUNT_W+2 cycles after each result.
// -----------------------------------------------------------------------------
module tb_freq_meter_core;

    localparam int G  = 1000;
    localparam int WA = 24;
    localparam int WB = 6;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    logic sigin  = 1'b0;

    always #5 sysclk = ~sysclk;

    freq_meter_core_if #(.COUNT_W(WA)) bus_a ();
    freq_meter_core_if #(.COUNT_W(WB)) bus_b ();

    assign bus_a.sigin = sigin;
    assign bus_b.sigin = sigin;

    freq_meter_core #(.GATE_CYCLES(G), .COUNT_W(WA)) dut_a (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus_a)
    );

    freq_meter_core #(.GATE_CYCLES(G), .COUNT_W(WB)) dut_b (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] to_bcd(input int v);
        bit [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // ---------------- stimulus generator ----------------
    int gen_mode  = 0;   // 0: constant level, 1: periodic
    int hi_len    = 1;
    int lo_len    = 1;
    int const_lvl = 0;
    int ph        = 0;

    always @(negedge sysclk) begin
        if (gen_mode == 1) begin
            ph++;
            if (sigin && ph >= hi_len) begin
                sigin = 1'b0;
                ph    = 0;
            end else if (!sigin && ph >= lo_len) begin
                sigin = 1'b1;
                ph    = 0;
            end
        end else begin
            sigin = const_lvl[0];
            ph    = 0;
        end
    end

    // ---------------- reference model ----------------
    int        wd[2] = '{WA, WB};
    bit        model_ok = 1'b0;
    int        n_edges;
    bit        hist[4];
    int        win[2];
    int        e_freq[2];
    bit        e_ovf[2];
    bit        e_vld[2];
    bit [31:0] e_bcd[2];
    bit        e_bvld[2];
    int        due[2];
    bit [31:0] bcd_val[2];

    always @(posedge sysclk) begin
        bit rise_ev;
        int maxv;
        if (reset) begin
            model_ok = 1'b1;
            n_edges  = 0;
            for (int j = 0; j < 4; j++) hist[j] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                win[i]     = 0;
                e_freq[i]  = 0;
                e_ovf[i]   = 1'b0;
                e_vld[i]   = 1'b0;
                e_bcd[i]   = '0;
                e_bvld[i]  = 1'b0;
                due[i]     = -1;
                bcd_val[i] = '0;
            end
        end else if (model_ok) begin
            n_edges++;
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = sigin;
            rise_ev = hist[2] & ~hist[3];
            for (int i = 0; i < 2; i++) begin
                e_vld[i]  = 1'b0;
                e_bvld[i] = 1'b0;
`ifdef FREQ_BCD_EN
                if (due[i] > 0) begin
                    due[i]--;
                    if (due[i] == 0) begin
                        e_bvld[i] = 1'b1;
                        e_bcd[i]  = bcd_val[i];
                        due[i]    = -1;
                    end
                end
`endif
                win[i] += int'(rise_ev);
                if (n_edges % G == 0) begin
                    maxv      = (1 << wd[i]) - 1;
                    e_freq[i] = (win[i] > maxv) ? maxv : win[i];
                    e_ovf[i]  = (win[i] > maxv);
                    e_vld[i]  = 1'b1;
                    win[i]    = 0;
`ifdef FREQ_BCD_EN
                    if (due[i] < 0) begin
                        due[i]     = wd[i] + 2;
                        bcd_val[i] = to_bcd(e_freq[i]);
                    end
`endif
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge sysclk) begin
        if (model_ok) begin
            check("a.freq",     32'(bus_a.freq),     32'(e_freq[0]));
            check("a.overflow", 32'(bus_a.overflow), 32'(e_ovf[0]));
            check("a.freq_vld", 32'(bus_a.freq_vld), 32'(e_vld[0]));
            check("a.freq_bcd", bus_a.freq_bcd,      e_bcd[0]);
            check("a.bcd_vld",  32'(bus_a.bcd_vld),  32'(e_bvld[0]));
            check("b.freq",     32'(bus_b.freq),     32'(e_freq[1]));
            check("b.overflow", 32'(bus_b.overflow), 32'(e_ovf[1]));
            check("b.freq_vld", 32'(bus_b.freq_vld), 32'(e_vld[1]));
            check("b.freq_bcd", bus_b.freq_bcd,      e_bcd[1]);
            check("b.bcd_vld",  32'(bus_b.bcd_vld),  32'(e_bvld[1]));
        end
    end

    // ---------------- directed + random sequence ----------------
    task automatic tick_n(input int k);
        repeat (k) @(posedge sysclk);
        #1;
    endtask

    task automatic wait_vld();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < G + 20; k++) begin
            @(posedge sysclk);
            #1;
            if (e_vld[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_vld_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int k;
        bit found;

        // Reset held with sigin toggling every cycle.
        reset    = 1'b1;
        gen_mode = 1;
        hi_len   = 1;
        lo_len   = 1;
        tick_n(5);
        check("rst_a_freq",     32'(bus_a.freq),     32'd0);
        check("rst_a_freq_vld", 32'(bus_a.freq_vld), 32'd0);
        check("rst_b_overflow", 32'(bus_b.overflow), 32'd0);
        check("rst_a_freq_bcd", bus_a.freq_bcd,      32'd0);

        // Period 8 input; first result 1000 edges after the last reset edge.
        hi_len = 4;
        lo_len = 4;
        reset  = 1'b0;
        found  = 1'b0;
        k      = 0;
        for (int c = 1; c <= G + 50; c++) begin
            @(posedge sysclk);
            #1;
            if (bus_a.freq_vld) begin
                k     = c;
                found = 1'b1;
                break;
            end
        end
        check("first_vld_edges", 32'(k), 32'(G));
        if (!found) check("first_vld_timeout", 32'd0, 32'd1);

        wait_vld();
        check("p8_a_freq",     32'(bus_a.freq),     32'd125);
        check("p8_a_overflow", 32'(bus_a.overflow), 32'd0);
        check("p8_b_freq",     32'(bus_b.freq),     32'd63);
        check("p8_b_overflow", 32'(bus_b.overflow), 32'd1);
`ifdef FREQ_BCD_EN
        tick_n(WA + 2);
        check("p8_a_bcd",     bus_a.freq_bcd,     32'h0000_0125);
        check("p8_a_bcd_vld", 32'(bus_a.bcd_vld), 32'd1);
        check("p8_b_bcd",     bus_b.freq_bcd,     32'h0000_0063);
`endif
        wait_vld();
        check("p8_a_freq_w3", 32'(bus_a.freq), 32'd125);

        // Idle input: zero count, no overflow, results still published.
        gen_mode  = 0;
        const_lvl = 0;
        wait_vld();
        wait_vld();
        check("idle_a_freq",     32'(bus_a.freq),     32'd0);
        check("idle_b_freq",     32'(bus_b.freq),     32'd0);
        check("idle_b_overflow", 32'(bus_b.overflow), 32'd0);
        check("idle_a_vld",      32'(bus_a.freq_vld), 32'd1);

        // Single 0->1 step counts once; constant high counts zero.
        tick_n($urandom_range(100, 800));
        const_lvl = 1;
        wait_vld();
        check("step_a_freq", 32'(bus_a.freq), 32'd1);
        check("step_b_freq", 32'(bus_b.freq), 32'd1);
        wait_vld();
        check("high_a_freq", 32'(bus_a.freq), 32'd0);

        // Rise landing exactly on the last cycle of a window.
        const_lvl = 0;
        found     = 1'b0;
        for (int c = 0; c < G + 5; c++) begin
            @(posedge sysclk);
            #1;
            if (n_edges % G == G - 3) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("tick_align_timeout", 32'd0, 32'd1);
        const_lvl = 1;
        wait_vld();
        check("tick_rise_a_freq", 32'(bus_a.freq), 32'd1);
        check("tick_rise_b_freq", 32'(bus_b.freq), 32'd1);
        wait_vld();
        check("after_tick_a_freq", 32'(bus_a.freq), 32'd0);

        // Random periods and levels, model-checked every cycle.
        repeat (6) begin
            gen_mode  = ($urandom_range(0, 3) == 0) ? 0 : 1;
            hi_len    = $urandom_range(2, 12);
            lo_len    = $urandom_range(2, 12);
            const_lvl = $urandom_range(0, 1);
            tick_n($urandom_range(150, 1600));
        end

        // Reset shortly after a result: discards the window and any
        // conversion in progress.
        gen_mode = 1;
        hi_len   = 3;
        lo_len   = 5;
        wait_vld();
        tick_n(5);
        reset = 1'b1;
        tick_n(3);
        reset = 1'b0;
        check("rst2_a_freq_bcd", bus_a.freq_bcd,     32'd0);
        check("rst2_a_freq",     32'(bus_a.freq),    32'd0);
        check("rst2_a_bcd_vld",  32'(bus_a.bcd_vld), 32'd0);
        wait_vld();
        wait_vld();
        check("rst2_a_freq_w2", 32'(bus_a.freq), 32'd125);
        tick_n(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
